// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// A double-buffered digit store accepts host writes into the shadow copy. The shadow is copied to
// the active copy only at a frame boundary, so multi-digit updates never tear. Each digit slot is
// DWELL = CLK_HZ/SCAN_HZ cycles long: BLANK_CYC cycles with all selects off, then SHOW.
// Optional feature macro: SEG_DIM_EN adds a bright[2:0] input that shortens the lit part of SHOW.
module seg_scan_ctrl #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SCAN_HZ   = 1000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
`ifdef SEG_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic       pending,
    output logic       frame_start,
    output logic [3:0] seg_sel,
    output logic [6:0] segment
);

    localparam int unsigned DWELL    = CLK_HZ / SCAN_HZ;
    localparam int unsigned SHOW_CYC = DWELL - BLANK_CYC;
    localparam int unsigned CW       = (DWELL > 2) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Cleared by reset and by en=0; the first enabled cycle afterwards opens a fresh frame.
    logic          run_q, run_d;
    logic          frame_q, frame_d;
    logic          pending_q, pending_d;
    logic [3:0]    shadow_q [4];
    logic [3:0]    active_q [4];
    logic [3:0]    seg_sel_q, seg_sel_d;
    logic [6:0]    segment_q, segment_d;
    logic          lit;

    // Active-high segment pattern, gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state for the slot sequencer; frame_d marks entry to the idx-0 BLANK slot.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        frame_d = 1'b0;
        if (!en) begin
            state_d = StBlank;
            idx_d   = 2'd0;
            cnt_d   = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            state_d = StBlank;
            idx_d   = 2'd0;
            cnt_d   = '0;
            run_d   = 1'b1;
            frame_d = 1'b1;
        end else begin
            unique case (state_q)
                StBlank: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StShow: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        frame_d = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q <= StBlank;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            frame_q <= frame_d;
        end
    end

    // A write in the commit cycle lands after the copy, so pending must stay set.
    always_comb begin
        pending_d = pending_q;
        if (frame_d) begin
            pending_d = 1'b0;
        end
        if (wr_en) begin
            pending_d = 1'b1;
        end
    end

    // Shadow/active digit store; the commit reads the pre-write shadow.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'h0;
                active_q[i] <= 4'h0;
            end
            pending_q <= 1'b0;
        end else begin
            if (frame_d) begin
                for (int i = 0; i < 4; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_en) begin
                shadow_q[wr_addr] <= wr_data;
            end
            pending_q <= pending_d;
        end
    end

`ifdef SEG_DIM_EN
    logic [2:0]    bright_q;
    logic [CW-1:0] lit_cyc;

    // Brightness is latched per frame so a change never alters a frame part-way through.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            bright_q <= 3'd7;
        end else if (frame_d) begin
            bright_q <= bright;
        end
    end

    // Lit portion of SHOW: ((bright+1)*SHOW_CYC)/8 cycles.
    always_comb begin
        lit_cyc = CW'(((32'(bright_q) + 32'd1) * SHOW_CYC) / 32'd8);
        lit     = en && (state_q == StShow) && (cnt_q < lit_cyc);
    end
`else
    // Digit is lit for the whole SHOW phase.
    always_comb begin
        lit = en && (state_q == StShow);
    end
`endif

    // Output decode, one cycle behind the sequencer state.
    always_comb begin
        seg_sel_d = 4'hF;
        segment_d = 7'h7F;
        if (lit) begin
            seg_sel_d = ~(4'b0001 << idx_q);
            segment_d = ~hex7(active_q[idx_q]);
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            seg_sel_q <= 4'hF;
            segment_q <= 7'h7F;
        end else begin
            seg_sel_q <= seg_sel_d;
            segment_q <= segment_d;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_q;
    assign seg_sel     = seg_sel_q;
    assign segment     = segment_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with CLK_HZ=1000, SCAN_HZ=100, BLANK_CYC=2 (10-cycle slot, 40-cycle frame).
// The reference model tracks the position within the frame as a single cycle count.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned SCAN_HZ   = 100;
    localparam int unsigned BLANK_CYC = 2;
    localparam int          SLOT      = 10;
    localparam int          FRAME     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       pending;
    logic       frame_start;
    logic [3:0] seg_sel;
    logic [6:0] segment;
`ifdef SEG_DIM_EN
    logic [2:0] bright = 3'd7;
`endif

    seg_scan_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk_100MHz  (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef SEG_DIM_EN
        .bright      (bright),
`endif
        .pending     (pending),
        .frame_start (frame_start),
        .seg_sel     (seg_sel),
        .segment     (segment)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state (describes the cycle just before the next clock edge).
    logic [3:0] m_shadow [4];
    logic [3:0] m_active [4];
    bit         m_pending = 1'b0;
    bit         m_run = 1'b0;
    int         m_t = 0;

    logic [3:0] e_sel;
    logic [6:0] e_seg;
    logic       e_fs;
    logic       e_pend;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare all outputs.
    task automatic tick(input bit r, input bit e, input bit w, input logic [1:0] a,
                        input logic [3:0] d);
        int         slot;
        bit         show;
        bit         fe;
        logic [3:0] onehot;
        rst = r;
        en = e;
        wr_en = w;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 4'h0;
                m_active[i] = 4'h0;
            end
            m_pending = 1'b0;
            m_run = 1'b0;
            m_t = 0;
            e_sel = 4'hF;
            e_seg = 7'h7F;
            e_fs = 1'b0;
        end else begin
            slot = m_t / SLOT;
            show = e && m_run && ((m_t % SLOT) >= int'(BLANK_CYC));
            onehot = 4'b0001 << slot;
            e_sel = show ? ~onehot : 4'hF;
            e_seg = show ? ~hex7(m_active[slot]) : 7'h7F;
            fe = e && (!m_run || ((m_t + 1) % FRAME == 0));
            e_fs = fe;
            if (fe) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                m_pending = 1'b0;
            end
            if (w) begin
                m_shadow[a] = d;
                m_pending = 1'b1;
            end
            if (!e) begin
                m_run = 1'b0;
                m_t = 0;
            end else if (fe) begin
                m_run = 1'b1;
                m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
        end
        e_pend = m_pending;
        #1;
        check("seg_sel", {4'h0, seg_sel}, {4'h0, e_sel});
        check("segment", {1'b0, segment}, {1'b0, e_seg});
        check("frame_start", {7'h0, frame_start}, {7'h0, e_fs});
        check("pending", {7'h0, pending}, {7'h0, e_pend});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    endtask

    initial begin
        bit found;

        // Reset
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
        tick(1'b1, 1'b0, 1'b0, 2'd0, 4'd0);

        // Free-running scan of all-zero digits
        idle(100);

        // Multi-digit update mid-frame
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 2'(i), 4'(i + 1));
        idle(90);

        // Write coinciding with the commit cycle
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_run && ((m_t + 1) % FRAME == 0)) found = 1'b1;
            else idle(1);
        end
        check("commit_reach", {7'h0, found}, 8'h01);
        tick(1'b0, 1'b1, 1'b1, 2'd2, 4'hA);
        idle(90);

        // Drop en during digit 2 SHOW
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_run && m_t == 25) found = 1'b1;
            else idle(1);
        end
        check("digit2_reach", {7'h0, found}, 8'h01);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        idle(60);

        // Reset during SHOW with uncommitted writes
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_run && (m_t % SLOT) >= int'(BLANK_CYC)) found = 1'b1;
            else idle(1);
        end
        check("show_reach", {7'h0, found}, 8'h01);
        tick(1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
        idle(60);

        // Randomized writes and enable drops
        for (int i = 0; i < 1200; i++) begin
            tick(1'b0, ($urandom_range(0, 59) != 0), ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
